// File: rtl/my_logic_pipe.sv
// Registered N-operand bitwise logic stage with a 2-entry output queue,
// valid/ready on both sides and a saturating delivered-result counter.
module my_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [2:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic [15:0]           txn_count
);

  logic [WIDTH-1:0] opnd [N_IN];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_opnd
      assign opnd[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] red_and, red_or, red_xor;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < N_IN; k++) begin
      red_and = red_and & opnd[k];
      red_or  = red_or  | opnd[k];
      red_xor = red_xor ^ opnd[k];
    end
  end

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op)
      3'd0:    res_data = red_and;
      3'd1:    res_data = red_or;
      3'd2:    res_data = red_xor;
      3'd3:    res_data = ~red_and;
      3'd4:    res_data = ~red_or;
      3'd5:    res_data = ~red_xor;
      3'd6:    res_data = ~opnd[0];
      default: res_err  = 1'b1;
    endcase
  end

  // Head register feeds the outputs directly, so it keeps its last value when the queue empties.
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_err_q,  head_err_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic             tail_err_q,  tail_err_d;
  logic [1:0]       count_q,     count_d;
  logic [15:0]      txn_q,       txn_d;

  logic push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;
  assign txn_count = txn_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    tail_data_d = tail_data_q;
    tail_err_d  = tail_err_q;
    count_d     = count_q;
    txn_d       = txn_q;
    if (clr) begin
      count_d = 2'd0;
      txn_d   = 16'd0;
    end else begin
      if (pop && (txn_q != 16'hFFFF)) txn_d = txn_q + 16'd1;
      case (count_q)
        2'd0: begin
          if (push) begin
            head_data_d = res_data;
            head_err_d  = res_err;
            count_d     = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data_d = res_data;
            head_err_d  = res_err;
          end else if (push) begin
            tail_data_d = res_data;
            tail_err_d  = res_err;
            count_d     = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low when full, so only a pop can occur here.
          if (pop) begin
            head_data_d = tail_data_q;
            head_err_d  = tail_err_q;
            count_d     = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      tail_data_q <= '0;
      tail_err_q  <= 1'b0;
      count_q     <= 2'd0;
      txn_q       <= 16'd0;
    end else begin
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      tail_data_q <= tail_data_d;
      tail_err_q  <= tail_err_d;
      count_q     <= count_d;
      txn_q       <= txn_d;
    end
  end

endmodule

// File: tb/tb_my_logic_pipe.sv
// Scoreboard bench for my_logic_pipe: a 1-bit/2-operand instance for the truth
// table and an 8-bit/3-operand instance for queueing, saturation, clr and reset.
module tb_my_logic_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Instance A: WIDTH=1, N_IN=2
  logic       clr_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a;
  logic [1:0] in_data_a;
  logic [2:0] op_a;
  logic [0:0] out_data_a;
  logic [15:0] txn_a;

  // Instance B: WIDTH=8, N_IN=3
  logic        clr_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b;
  logic [23:0] in_data_b;
  logic [2:0]  op_b;
  logic [7:0]  out_data_b;
  logic [15:0] txn_b;

  my_logic_pipe #(.WIDTH(1), .N_IN(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .op(op_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_err(out_err_a), .txn_count(txn_a)
  );

  my_logic_pipe #(.WIDTH(8), .N_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .op(op_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_err(out_err_b), .txn_count(txn_b)
  );

  // Expected {err, data} per accepted push
  logic [1:0] q_a [$];
  logic [8:0] q_b [$];

  always @(negedge clk) begin : mon_a
    logic [1:0] e;
    if (!rst_n || clr_a) begin
      q_a.delete();
    end else if (out_valid_a && out_ready_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL pop_a: unexpected result err=%0d data=%h, required no result", out_err_a, out_data_a);
      end else begin
        e = q_a.pop_front();
        if ({out_err_a, out_data_a} !== e) begin
          errors++;
          $display("FAIL pop_a: got err=%0d data=%h, required err=%0d data=%h",
                   out_err_a, out_data_a, e[1], e[0]);
        end else if (verbose) begin
          $display("pop_a err=%0d data=%h ok", out_err_a, out_data_a);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [8:0] e;
    if (!rst_n || clr_b) begin
      q_b.delete();
    end else if (out_valid_b && out_ready_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL pop_b: unexpected result err=%0d data=%h, required no result", out_err_b, out_data_b);
      end else begin
        e = q_b.pop_front();
        if ({out_err_b, out_data_b} !== e) begin
          errors++;
          $display("FAIL pop_b: got err=%0d data=%h, required err=%0d data=%h",
                   out_err_b, out_data_b, e[8], e[7:0]);
        end else if (verbose) begin
          $display("pop_b err=%0d data=%h ok", out_err_b, out_data_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_a(input logic [1:0] d, input logic [2:0] o, input logic [1:0] e);
    int n = 0;
    in_data_a = d; op_a = o; in_valid_a = 1'b1;
    while (!in_ready_a && n < 50) begin tick(); n++; end
    if (!in_ready_a) begin
      checks++; errors++;
      $display("FAIL send_a: in_ready stuck at 0, required 1 within 50 cycles");
    end else begin
      q_a.push_back(e);
      tick();
    end
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [23:0] d, input logic [2:0] o, input logic [8:0] e);
    int n = 0;
    in_data_b = d; op_b = o; in_valid_b = 1'b1;
    while (!in_ready_b && n < 50) begin tick(); n++; end
    if (!in_ready_b) begin
      checks++; errors++;
      $display("FAIL send_b: in_ready stuck at 0, required 1 within 50 cycles");
    end else begin
      q_b.push_back(e);
      tick();
    end
    in_valid_b = 1'b0;
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 100) begin tick(); n++; end
    check("drain_b left", q_b.size(), 0);
  endtask

  task automatic pulse_clr_b();
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
  endtask

  logic [3:0] tt [8];
  logic [7:0] eb [8];

  initial begin
    // Bit i of tt[op] is the result for operand pair i = {op1, op0}
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0101; tt[7] = 4'b0000;
    // Operands 0xF0, 0xCC, 0xAA
    eb[0] = 8'h80; eb[1] = 8'hFE; eb[2] = 8'h96; eb[3] = 8'h7F;
    eb[4] = 8'h01; eb[5] = 8'h69; eb[6] = 8'h0F; eb[7] = 8'h00;

    rst_n = 1'b0;
    clr_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; op_a = '0; out_ready_a = 1'b1;
    clr_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; op_b = '0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    check("rst_a out_valid", out_valid_a, 0);
    check("rst_a in_ready", in_ready_a, 1);
    check("rst_a txn", txn_a, 0);
    check("rst_b out_valid", out_valid_b, 0);
    check("rst_b in_ready", in_ready_b, 1);
    check("rst_b txn", txn_b, 0);
    check("rst_b out_data", out_data_b, 0);
    check("rst_b out_err", out_err_b, 0);

    // Truth table on the 1-bit instance, one push per cycle with out_ready held high
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 4; i++) begin
        logic [1:0] pr;
        logic [3:0] row;
        logic [1:0] e;
        pr  = i[1:0];
        row = tt[o];
        e   = {(o == 7), row[i]};
        send_a(pr, o[2:0], e);
        check($sformatf("lat_a op%0d pair%0d valid", o, i), out_valid_a, 1);
        check($sformatf("lat_a op%0d pair%0d result", o, i), {out_err_a, out_data_a}, e);
      end
    end
    tick();
    check("a txn after 32", txn_a, 32);

    // Multi-operand ops on the 8-bit instance
    out_ready_b = 1'b1;
    for (int o = 0; o < 8; o++) begin
      send_b({8'hAA, 8'hCC, 8'hF0}, o[2:0], {(o == 7), eb[o]});
    end
    drain_b();

    // Backpressure and full-queue pop
    pulse_clr_b();
    out_ready_b = 1'b0;
    send_b({8'h00, 8'h00, 8'h11}, 3'd1, 9'h011);
    send_b({8'h00, 8'h00, 8'h22}, 3'd1, 9'h022);
    check("bp full in_ready", in_ready_b, 0);
    check("bp head", out_data_b, 8'h11);
    in_data_b = {8'h00, 8'h00, 8'h33}; op_b = 3'd1; in_valid_b = 1'b1;
    tick(); tick();
    check("bp third refused", in_ready_b, 0);
    check("bp head held", out_data_b, 8'h11);
    in_valid_b = 1'b0;
    out_ready_b = 1'b1;
    check("bp pop-cycle in_ready", in_ready_b, 0);
    tick();
    check("bp next in_ready", in_ready_b, 1);
    check("bp second head", out_data_b, 8'h22);
    check("bp txn 1", txn_b, 1);
    tick();
    check("bp empty", out_valid_b, 0);
    check("bp txn 2", txn_b, 2);

    // Push and pop together at occupancy 1
    out_ready_b = 1'b0;
    send_b({8'h00, 8'h00, 8'h41}, 3'd1, 9'h041);
    out_ready_b = 1'b1;
    send_b({8'h00, 8'h00, 8'h42}, 3'd1, 9'h042);
    check("pp out_valid", out_valid_b, 1);
    check("pp in_ready", in_ready_b, 1);
    check("pp head", out_data_b, 8'h42);
    check("pp txn 3", txn_b, 3);
    tick();
    check("pp empty", out_valid_b, 0);
    check("pp txn 4", txn_b, 4);

    // Saturation: 65537 pops from zero
    pulse_clr_b();
    check("sat start txn", txn_b, 0);
    verbose = 1'b0;
    for (int n = 0; n < 65537; n++) begin
      send_b({8'h00, 8'h00, 8'h5A}, 3'd1, 9'h05A);
    end
    drain_b();
    verbose = 1'b1;
    check("sat txn", txn_b, 16'hFFFF);

    // clr together with push and pop
    send_b({8'h00, 8'h00, 8'h77}, 3'd1, 9'h077);
    clr_b = 1'b1;
    in_data_b = {8'h00, 8'h00, 8'h99}; op_b = 3'd1; in_valid_b = 1'b1;
    tick();
    clr_b = 1'b0; in_valid_b = 1'b0;
    check("clr out_valid", out_valid_b, 0);
    check("clr txn", txn_b, 0);
    repeat (3) tick();
    check("clr push discarded", out_valid_b, 0);
    check("clr txn stays", txn_b, 0);

    // Asynchronous reset with the queue full
    send_b({8'h00, 8'h00, 8'h10}, 3'd1, 9'h010);
    tick();
    check("ar txn before", txn_b, 1);
    out_ready_b = 1'b0;
    send_b({8'h00, 8'h00, 8'h21}, 3'd1, 9'h021);
    send_b({8'h00, 8'h00, 8'h32}, 3'd1, 9'h032);
    check("ar full", in_ready_b, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar out_valid", out_valid_b, 0);
    check("ar in_ready", in_ready_b, 1);
    check("ar txn", txn_b, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready_b = 1'b1;
    tick(); tick();
    check("ar nothing popped", out_valid_b, 0);

    check("q_a empty at end", q_a.size(), 0);
    check("q_b empty at end", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_logic_pipe.md
# my_logic_pipe

Parametrised, registered successor to the single-gate `my_and` cell. It applies one of eight selectable bitwise logic operations across N_IN operands of WIDTH bits each, and buffers the results in a 2-entry output queue with valid/ready handshakes on both sides. It also keeps a saturating count of delivered results. It sits between a producer and a consumer as a drop-in logic stage that tolerates consumer stalls.

## Interface
Parameters:
- WIDTH, default 8: bits per operand and result; legal range 1..32.
- N_IN, default 2: operand count; legal range 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low. Deassertion is synchronised externally.
- clr  in  1  synchronous flush of the queue and the counter.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  N_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- op  in  3  operation select, sampled with in_data.
- out_valid  out  1  head result is valid.
- out_ready  in  1  consumer takes the head result.
- out_data  out  WIDTH  head result.
- out_err  out  1  head result came from an illegal op.
- txn_count  out  16  results delivered since reset or clr.

## Operation
- A push happens when in_valid && in_ready. A pop happens when out_valid && out_ready.
- Result is computed bitwise over all N_IN operands:
  - 0 = AND
  - 1 = OR
  - 2 = XOR (odd parity per bit)
  - 3 = NAND
  - 4 = NOR
  - 5 = XNOR
  - 6 = NOT of operand 0 (other operands ignored)
  - 7 = illegal: result is all zeros and the entry's err flag is set to 1
- For ops 0..6 the err flag is 0.
- The queue is a 2-entry FIFO with storage {data, err} per entry and an occupancy count of 0..2.
  - in_ready = (occupancy < 2). It depends only on registered state, with no combinational path from out_ready.
  - out_valid = (occupancy > 0). out_data and out_err always show the head entry.
  - A push and a pop in the same cycle leave occupancy unchanged and keep FIFO order.
  - When full, in_ready is 0 even if a pop happens that cycle. The freed slot becomes visible in the next cycle.
- txn_count increments by 1 on each pop. It saturates at 0xFFFF and never wraps.
- clr has priority over push and pop in the same cycle:
  - occupancy becomes 0 and txn_count becomes 0;
  - a push presented in that cycle is discarded;
  - a pop presented in that cycle is not counted.
- While out_valid = 0, out_data and out_err hold their last value. The bench ignores them.

## Timing
- Reset values (rst_n = 0, taking effect immediately and independent of clk):
  - occupancy 0, so out_valid = 0 and in_ready = 1;
  - out_data = 0, out_err = 0, txn_count = 0.
- Reset asserted mid-operation discards all queued entries with no further pops.
- Latency: a push at rising edge k gives out_valid = 1 after edge k, with the result visible in cycle k+1 if the queue was empty.
- Throughput: 1 result per cycle while out_ready stays 1.
- With out_ready held at 0, two pushes fill the queue, after which in_ready = 0.
- Handshake rules:
  - Producer must hold in_data and op stable while in_valid = 1 and in_ready = 0.
  - The block holds out_data and out_err stable while out_valid = 1 and out_ready = 0.
- txn_count updates at the same edge as the pop.

## Test plan
- Reset and truth table, WIDTH = 1, N_IN = 2: hold out_ready = 1, sweep all 4 operand pairs for ops 0..5.
  - AND gives 0,0,0,1 for (0,0),(1,0),(0,1),(1,1); each result appears 1 cycle after its push; out_err = 0.
  - After reset, before any push: out_valid = 0, in_ready = 1, txn_count = 0.
- Multi-operand, WIDTH = 8, N_IN = 3, operands 0xF0, 0xCC, 0xAA:
  - AND gives 0x80, OR 0xFE, XOR 0x96, NOR 0x01, NAND 0x7F, XNOR 0x69.
  - op 6 gives 0x0F.
  - op 7 gives out_data 0x00 with out_err = 1.
- Backpressure: out_ready = 0, push 0x11 then 0x22.
  - in_ready drops to 0 after the second push, and a third in_valid is not accepted.
  - Then set out_ready = 1: results pop in order 0x11, 0x22, and txn_count reaches 2.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and order is preserved.
  - At occupancy 2 with a pop: in_ready stays 0 that cycle and goes to 1 the next cycle.
- Saturation and clr: force 65 537 pops. txn_count stops at 0xFFFF.
  - Assert clr in the same cycle as a push and a pop: out_valid = 0 and txn_count = 0 next cycle; the pushed data is never seen.
- Asynchronous reset mid-stream: with the queue full, pulse rst_n low between clock edges.
  - out_valid falls immediately, with no edge needed; in_ready = 1; txn_count = 0.
